// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
//   Adds two 4*NIBBLES-bit operands on a single 4-bit ripple_adder, one
//   nibble per clock from LSB to MSB, with a registered inter-nibble carry.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand request from producer
//   in_ready   sequencer accepts a request this cycle
//   in_a/in_b  W-bit addends, in_ci carry into nibble 0
//   out_valid  result available
//   out_ready  consumer takes the result this cycle
//   out_sum    (A + B + ci) mod 2^W, out_co carry out of the top nibble
//   busy       high whenever the FSM is not IDLE
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. A producer holds valid (and its data) until it sees ready;
// the sequencer never samples operands outside such a transfer, and keeps
// out_valid/out_sum/out_co stable until the consumer raises out_ready.

module ripple_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module serial_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_ci,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_co,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_sh, b_sh, acc, acc_nxt;
  logic          carry_q;
  logic [CW-1:0] cnt;
  logic [3:0]    nib_sum;
  logic          nib_co;
  logic          accept;
  logic          last_nib;

  ripple_adder u_adder (
    .a   (a_sh[3:0]),
    .b   (b_sh[3:0]),
    .ci  (carry_q),
    .sum (nib_sum),
    .co  (nib_co)
  );

  // The fresh nibble enters at the MSB; with a single nibble there is
  // nothing older to shift down.
  generate
    if (NIBBLES == 1) begin : g_acc_one
      assign acc_nxt = nib_sum;
    end else begin : g_acc_many
      assign acc_nxt = {nib_sum, acc[W-1:4]};
    end
  endgenerate

  // Ready is held low during reset so no request is taken while clearing.
  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_nib  = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      out_sum <= '0;
      out_co  <= 1'b0;
    end else if (accept) begin
      a_sh    <= in_a;
      b_sh    <= in_b;
      carry_q <= in_ci;
      cnt     <= '0;
    end else if (state == RUN) begin
      acc     <= acc_nxt;
      a_sh    <= a_sh >> 4;
      b_sh    <= b_sh >> 4;
      carry_q <= nib_co;
      cnt     <= cnt + CW'(1);
      if (last_nib) begin
        out_sum <= acc_nxt;
        out_co  <= nib_co;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer: a 4-nibble instance exercises
// latency, carry ripple, backpressure, back-to-back and reset; a 1-nibble
// instance covers the degenerate single-RUN-cycle case.

module tb_serial_add_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ci, out_ready;
  logic [15:0] in_a, in_b;
  logic        in_ready, out_valid, out_co, busy;
  logic [15:0] out_sum;

  logic        in_valid1, in_ci1, out_ready1;
  logic [3:0]  in_a1, in_b1;
  logic        in_ready1, out_valid1, out_co1, busy1;
  logic [3:0]  out_sum1;

  int n_assert = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  serial_add_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co), .busy(busy)
  );

  serial_add_sequencer #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_ci(in_ci1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_sum(out_sum1), .out_co(out_co1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single operation from IDLE, checking latency, result and return to IDLE.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [15:0] exp_sum, input logic exp_co);
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk({tag, "_early_valid"}, out_valid, 0);
    end
    step();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, exp_sum);
    chk({tag, "_co"}, out_co, exp_co);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, out_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_hold_sum"}, out_sum, exp_sum);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_ci1 = 1'b0; out_ready1 = 1'b0;
    step(); step();

    // reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_co", out_co, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // basic additions
    do_op("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    do_op("ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_op("ffff_ci", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // backpressure: result held, pending request not captured
    in_a = 16'h00FF; in_b = 16'h0F01; in_ci = 1'b0; in_valid = 1'b1;
    step();
    in_a = 16'h1111; in_b = 16'h1111; in_ci = 1'b0; // stays pending
    for (int i = 0; i < 4; i++) step();
    chk("bp_valid0", out_valid, 1);
    chk("bp_sum0", out_sum, 16'h1000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 16'h1000);
      chk("bp_co", out_co, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", in_ready, 1);
    step(); // both handshakes on this edge
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_next_busy", busy, 1);
    chk("bp_next_valid", out_valid, 0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("bp_next_early", out_valid, 0);
      chk("bp_old_sum_held", out_sum, 16'h1000);
    end
    step();
    chk("bp_next_valid1", out_valid, 1);
    chk("bp_next_sum", out_sum, 16'h2222);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle", busy, 0);

    // back-to-back: results every 5 cycles without passing through IDLE
    begin
      logic [15:0] ta[3], tb_[3], ts[3];
      logic        tc[3], tco[3];
      ta[0] = 16'h1111; tb_[0] = 16'h2222; tc[0] = 1'b0; ts[0] = 16'h3333; tco[0] = 1'b0;
      ta[1] = 16'hABCD; tb_[1] = 16'h1234; tc[1] = 1'b0; ts[1] = 16'hBE01; tco[1] = 1'b0;
      ta[2] = 16'h8000; tb_[2] = 16'h8000; tc[2] = 1'b1; ts[2] = 16'h0001; tco[2] = 1'b1;
      in_a = ta[0]; in_b = tb_[0]; in_ci = tc[0]; in_valid = 1'b1; out_ready = 1'b1;
      step();
      for (int j = 0; j < 3; j++) begin
        for (int i = 1; i < 4; i++) begin
          step();
          chk("b2b_early", out_valid, 0);
          chk("b2b_busy", busy, 1);
        end
        step();
        chk("b2b_valid", out_valid, 1);
        chk("b2b_sum", out_sum, ts[j]);
        chk("b2b_co", out_co, tco[j]);
        if (j < 2) begin
          in_a = ta[j+1]; in_b = tb_[j+1]; in_ci = tc[j+1];
        end else begin
          in_valid = 1'b0;
        end
        step();
        chk("b2b_no_idle", busy, (j < 2) ? 1 : 0);
      end
      out_ready = 1'b0;
    end

    // reset in the second RUN cycle
    in_a = 16'h8888; in_b = 16'h8888; in_ci = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_sum", out_sum, 0);
    chk("mrst_co", out_co, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("mrst_release_ready", in_ready, 1);
    do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

    // single-nibble instance
    in_a1 = 4'hF; in_b1 = 4'h1; in_ci1 = 1'b1; in_valid1 = 1'b1;
    #1;
    chk("n1_in_ready", in_ready1, 1);
    step();
    in_valid1 = 1'b0;
    chk("n1_busy", busy1, 1);
    chk("n1_early", out_valid1, 0);
    step();
    chk("n1_valid", out_valid1, 1);
    chk("n1_sum", out_sum1, 4'h1);
    chk("n1_co", out_co1, 1);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("n1_idle", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
